// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: load results have strict priority over a small
// in-order FIFO of ALU results, with per-register ordering enforced against loads.
module writeback_arbiter #(
   parameter int unsigned ALU_FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_key,
   input  logic [31:0] alu_value,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_key,
   input  logic [31:0] mem_value,
   output logic        portD_enable,
   output logic [4:0]  portD_key,
   output logic [31:0] portD_value,
   output logic [31:0] busy_mask,
   output logic [3:0]  fifo_count
);

   localparam int unsigned KEY_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned PTR_W  = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;

   typedef struct packed {
      logic [KEY_W-1:0]  key;
      logic [DATA_W-1:0] value;
   } wb_entry_t;

   wb_entry_t                 fifo_mem [ALU_FIFO_DEPTH];
   logic [ALU_FIFO_DEPTH-1:0] fifo_vld;
   logic [PTR_W-1:0]          head;
   logic [PTR_W-1:0]          tail;

   logic key_hazard;
   logic alu_fire;
   logic mem_fire;
   logic push;
   logic mem_write;
   logic pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(ALU_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Key lookup across valid FIFO entries feeds both the load hazard and busy_mask.
   always_comb begin
      key_hazard = 1'b0;
      busy_mask  = '0;
      for (int i = 0; i < int'(ALU_FIFO_DEPTH); i++) begin
         if (fifo_vld[i]) begin
            if (fifo_mem[i].key == mem_key) key_hazard = 1'b1;
            busy_mask[fifo_mem[i].key] = 1'b1;
         end
      end
      if (portD_enable) busy_mask[portD_key] = 1'b1;
      busy_mask[0] = 1'b0;
   end

   assign alu_ready = reset_n && (fifo_count < CNT_W'(ALU_FIFO_DEPTH));
   assign mem_ready = reset_n && !((mem_key != '0) && key_hazard);

   assign alu_fire  = alu_valid && alu_ready;
   assign mem_fire  = mem_valid && mem_ready;
   assign push      = alu_fire && (alu_key != '0);
   assign mem_write = mem_fire && (mem_key != '0);
   assign pop       = !mem_write && (fifo_count != '0);

   // FIFO control and registered write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_vld     <= '0;
         head         <= '0;
         tail         <= '0;
         fifo_count   <= '0;
         portD_enable <= 1'b0;
         portD_key    <= '0;
         portD_value  <= '0;
      end else begin
         if (push) begin
            fifo_vld[tail] <= 1'b1;
            tail           <= ptr_inc(tail);
         end
         if (pop) begin
            fifo_vld[head] <= 1'b0;
            head           <= ptr_inc(head);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase

         if (mem_write) begin
            portD_enable <= 1'b1;
            portD_key    <= mem_key;
            portD_value  <= mem_value;
         end else if (pop) begin
            portD_enable <= 1'b1;
            portD_key    <= fifo_mem[head].key;
            portD_value  <= fifo_mem[head].value;
         end else begin
            portD_enable <= 1'b0;
            portD_key    <= '0;
            portD_value  <= '0;
         end
      end
   end

   // Payload storage needs no reset; validity is tracked in fifo_vld.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[tail] <= '{key: alu_key, value: alu_value};
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scenario bench for writeback_arbiter; expected port D writes are queued as
// stimulus is driven and checked by a monitor whenever port D writes.
module tb_writeback_arbiter;

   typedef struct packed {
      logic [4:0]  key;
      logic [31:0] value;
   } wr_t;

   logic        clk;
   logic        reset_n;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_key;
   logic [31:0] alu_value;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_key;
   logic [31:0] mem_value;
   logic        portD_enable;
   logic [4:0]  portD_key;
   logic [31:0] portD_value;
   logic [31:0] busy_mask;
   logic [3:0]  fifo_count;

   int  tests_run    = 0;
   int  tests_failed = 0;
   wr_t exp_q[$];
   wr_t mon_e;

   writeback_arbiter #(.ALU_FIFO_DEPTH(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_key      (alu_key),
      .alu_value    (alu_value),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_key      (mem_key),
      .mem_value    (mem_value),
      .portD_enable (portD_enable),
      .portD_key    (portD_key),
      .portD_value  (portD_value),
      .busy_mask    (busy_mask),
      .fifo_count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every port D write must match the oldest expected write.
   always @(negedge clk) begin
      if (reset_n) begin
         if (portD_enable) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_write key=%0d value=%h (no write expected)", portD_key, portD_value);
            end else begin
               mon_e = exp_q.pop_front();
               if (portD_key !== mon_e.key || portD_value !== mon_e.value) begin
                  tests_failed++;
                  $display("FAIL write_data got key=%0d value=%h expected key=%0d value=%h",
                           portD_key, portD_value, mon_e.key, mon_e.value);
               end
            end
         end else begin
            tests_run++;
            if (portD_key !== 5'd0 || portD_value !== 32'd0) begin
               tests_failed++;
               $display("FAIL idle_port got key=%0d value=%h expected key=0 value=0", portD_key, portD_value);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_alu(input logic v, input logic [4:0] k, input logic [31:0] d);
      alu_valid = v;
      alu_key   = k;
      alu_value = d;
   endtask

   task automatic drive_mem(input logic v, input logic [4:0] k, input logic [31:0] d);
      mem_valid = v;
      mem_key   = k;
      mem_value = d;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_mem(1'b0, 5'd0, 32'd0);
      #12;
      tests_run++;
      if ({portD_enable, portD_key, portD_value} !== 38'd0) begin
         tests_failed++;
         $display("FAIL reset_portd got en=%b key=%0d value=%h expected all 0", portD_enable, portD_key, portD_value);
      end
      tests_run++;
      if (busy_mask !== 32'd0 || fifo_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_state got busy=%h count=%0d expected 0 0", busy_mask, fifo_count);
      end
      tests_run++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ready got alu=%b mem=%b expected 0 0", alu_ready, mem_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      tests_run++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL release_ready got alu=%b mem=%b expected 1 1", alu_ready, mem_ready);
      end
      step();
      tests_run++;
      if (fifo_count !== 4'd0 || portD_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL release_idle got count=%0d en=%b expected 0 0", fifo_count, portD_enable);
      end
   endtask

   task automatic test_alu_only();
      step();
      drive_alu(1'b1, 5'd5, 32'h1111_1111);
      exp_q.push_back('{key: 5'd5, value: 32'h1111_1111});
      #1;
      tests_run++;
      if (alu_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL alu_only_ready got %b expected 1", alu_ready);
      end
      step();
      drive_alu(1'b0, 5'd0, 32'd0);
      tests_run++;
      if (fifo_count !== 4'd1 || busy_mask !== 32'h0000_0020 || portD_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL alu_only_queued got count=%0d busy=%h en=%b expected 1 00000020 0",
                  fifo_count, busy_mask, portD_enable);
      end
      step();
      tests_run++;
      if (portD_enable !== 1'b1 || busy_mask !== 32'h0000_0020 || fifo_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL alu_only_pop got en=%b busy=%h count=%0d expected 1 00000020 0",
                  portD_enable, busy_mask, fifo_count);
      end
      step();
      tests_run++;
      if (portD_enable !== 1'b0 || busy_mask !== 32'd0) begin
         tests_failed++;
         $display("FAIL alu_only_done got en=%b busy=%h expected 0 00000000", portD_enable, busy_mask);
      end
   endtask

   task automatic test_simultaneous();
      drive_alu(1'b1, 5'd3, 32'h0000_000A);
      drive_mem(1'b1, 5'd4, 32'h0000_000B);
      exp_q.push_back('{key: 5'd4, value: 32'h0000_000B});
      exp_q.push_back('{key: 5'd3, value: 32'h0000_000A});
      #1;
      tests_run++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_ready got alu=%b mem=%b expected 1 1", alu_ready, mem_ready);
      end
      step();
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_mem(1'b0, 5'd0, 32'd0);
      tests_run++;
      if (fifo_count !== 4'd1 || busy_mask !== 32'h0000_0018) begin
         tests_failed++;
         $display("FAIL simul_state got count=%0d busy=%h expected 1 00000018", fifo_count, busy_mask);
      end
      step();
      step();
      tests_run++;
      if (fifo_count !== 4'd0 || portD_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL simul_drain got count=%0d en=%b expected 0 0", fifo_count, portD_enable);
      end
   endtask

   task automatic test_backpressure();
      // Loads always win, so the order is all three loads then the ALU results.
      for (int i = 0; i < 3; i++) exp_q.push_back('{key: 5'(7 + i), value: 32'h700 + 32'(i)});
      for (int i = 0; i < 3; i++) exp_q.push_back('{key: 5'(10 + i), value: 32'hA00 + 32'(i)});
      drive_mem(1'b1, 5'd7, 32'h700);
      drive_alu(1'b1, 5'd10, 32'hA00);
      step();
      drive_mem(1'b1, 5'd8, 32'h701);
      drive_alu(1'b1, 5'd11, 32'hA01);
      #1;
      tests_run++;
      if (alu_ready !== 1'b1 || fifo_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL bp_second got ready=%b count=%0d expected 1 1", alu_ready, fifo_count);
      end
      step();
      drive_mem(1'b1, 5'd9, 32'h702);
      drive_alu(1'b1, 5'd12, 32'hA02);
      #1;
      tests_run++;
      if (alu_ready !== 1'b0 || fifo_count !== 4'd2) begin
         tests_failed++;
         $display("FAIL bp_full got ready=%b count=%0d expected 0 2", alu_ready, fifo_count);
      end
      step();
      drive_mem(1'b0, 5'd0, 32'd0);
      #1;
      tests_run++;
      if (alu_ready !== 1'b0 || fifo_count !== 4'd2) begin
         tests_failed++;
         $display("FAIL bp_hold got ready=%b count=%0d expected 0 2", alu_ready, fifo_count);
      end
      step();
      tests_run++;
      if (alu_ready !== 1'b1 || fifo_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL bp_reopen got ready=%b count=%0d expected 1 1", alu_ready, fifo_count);
      end
      step();
      drive_alu(1'b0, 5'd0, 32'd0);
      tests_run++;
      if (fifo_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL bp_pushpop got count=%0d expected 1", fifo_count);
      end
      step();
      step();
      tests_run++;
      if (fifo_count !== 4'd0 || busy_mask !== 32'd0) begin
         tests_failed++;
         $display("FAIL bp_drained got count=%0d busy=%h expected 0 00000000", fifo_count, busy_mask);
      end
   endtask

   task automatic test_hazard();
      drive_alu(1'b1, 5'd6, 32'h66);
      drive_mem(1'b1, 5'd20, 32'h20);
      exp_q.push_back('{key: 5'd20, value: 32'h20});
      exp_q.push_back('{key: 5'd6, value: 32'h66});
      step();
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_mem(1'b1, 5'd6, 32'h60);
      exp_q.push_back('{key: 5'd6, value: 32'h60});
      #1;
      tests_run++;
      if (mem_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL hazard_block got mem_ready=%b expected 0", mem_ready);
      end
      tests_run++;
      if (busy_mask !== 32'h0010_0040) begin
         tests_failed++;
         $display("FAIL hazard_busy got %h expected 00100040", busy_mask);
      end
      step();
      tests_run++;
      if (mem_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL hazard_release got mem_ready=%b expected 1", mem_ready);
      end
      step();
      drive_mem(1'b0, 5'd0, 32'd0);
      step();
      tests_run++;
      if (fifo_count !== 4'd0 || portD_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL hazard_done got count=%0d en=%b expected 0 0", fifo_count, portD_enable);
      end
   endtask

   task automatic test_x0();
      drive_alu(1'b1, 5'd0, 32'hDEAD);
      drive_mem(1'b1, 5'd0, 32'hBEEF);
      #1;
      tests_run++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL x0_ready got alu=%b mem=%b expected 1 1", alu_ready, mem_ready);
      end
      step();
      drive_alu(1'b1, 5'd9, 32'h99);
      drive_mem(1'b1, 5'd21, 32'h21);
      exp_q.push_back('{key: 5'd21, value: 32'h21});
      exp_q.push_back('{key: 5'd9, value: 32'h99});
      tests_run++;
      if (portD_enable !== 1'b0 || busy_mask !== 32'd0 || fifo_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL x0_discard got en=%b busy=%h count=%0d expected 0 00000000 0",
                  portD_enable, busy_mask, fifo_count);
      end
      step();
      drive_alu(1'b1, 5'd0, 32'h1234);
      drive_mem(1'b1, 5'd0, 32'h5678);
      #1;
      tests_run++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || fifo_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL x0_pending got alu=%b mem=%b count=%0d expected 1 1 1", alu_ready, mem_ready, fifo_count);
      end
      step();
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_mem(1'b0, 5'd0, 32'd0);
      tests_run++;
      if (portD_enable !== 1'b1 || fifo_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL x0_nonblock got en=%b count=%0d expected 1 0", portD_enable, fifo_count);
      end
      step();
   endtask

   task automatic test_reset_midstream();
      drive_mem(1'b1, 5'd1, 32'h1);
      drive_alu(1'b1, 5'd2, 32'h2);
      exp_q.push_back('{key: 5'd1, value: 32'h1});
      step();
      drive_mem(1'b1, 5'd3, 32'h3);
      drive_alu(1'b1, 5'd4, 32'h4);
      exp_q.push_back('{key: 5'd3, value: 32'h3});
      step();
      drive_mem(1'b0, 5'd0, 32'd0);
      drive_alu(1'b0, 5'd0, 32'd0);
      tests_run++;
      if (fifo_count !== 4'd2) begin
         tests_failed++;
         $display("FAIL mid_fill got count=%0d expected 2", fifo_count);
      end
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({portD_enable, portD_key, portD_value} !== 38'd0 || busy_mask !== 32'd0 || fifo_count !== 4'd0
          || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset got en=%b key=%0d value=%h busy=%h count=%0d alu=%b mem=%b expected all 0",
                  portD_enable, portD_key, portD_value, busy_mask, fifo_count, alu_ready, mem_ready);
      end
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         tests_run++;
         if (portD_enable !== 1'b0 || fifo_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_after cycle=%0d got en=%b count=%0d expected 0 0", i, portD_enable, fifo_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_simultaneous();
      test_backpressure();
      test_hazard();
      test_x0();
      test_reset_midstream();
      step();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL missing_writes got %0d outstanding expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter ALU_FIFO_DEPTH, default 2, sets the number of buffered ALU results (legal range 2..8).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 alu_valid  input  1  ALU result offered this cycle.
REQ-005 alu_ready  output  1  arbiter accepts the ALU result this cycle.
REQ-006 alu_key  input  5  destination register of the ALU result.
REQ-007 alu_value  input  32  ALU result data.
REQ-008 mem_valid  input  1  load result offered this cycle.
REQ-009 mem_ready  output  1  arbiter accepts the load result this cycle.
REQ-010 mem_key  input  5  destination register of the load result.
REQ-011 mem_value  input  32  load result data.
REQ-012 portD_enable  output  1  register-file write enable, registered.
REQ-013 portD_key  output  5  register-file write index, registered.
REQ-014 portD_value  output  32  register-file write data, registered.
REQ-015 busy_mask  output  32  bit k = a write to register k is held inside the arbiter.
REQ-016 fifo_count  output  4  number of valid ALU FIFO entries.

Function
REQ-017 Handshakes: transfer occurs on a rising edge when valid and ready are both high; a producer holds key/value stable while valid is high and ready is low.
REQ-018 alu_ready = (fifo_count < ALU_FIFO_DEPTH); it is not raised by a same-cycle pop.
REQ-019 An accepted ALU result with alu_key != 0 is pushed onto the tail of the FIFO; one with alu_key == 0 completes the handshake and is discarded.
REQ-020 mem_ready is high unless mem_key != 0 and it equals the key of some valid FIFO entry; this keeps writes to a register in program order.
REQ-021 Per-edge write selection, in priority order:
- An accepted load with mem_key != 0 is registered onto port D.
- Otherwise, if the FIFO is non-empty, the head is popped onto port D.
- Otherwise portD_enable = 0.
REQ-022 An accepted load with mem_key == 0 is discarded and does not block a FIFO pop on that edge.
REQ-023 When portD_enable = 0, portD_key = 0 and portD_value = 0.
REQ-024 Latency:
- Load accepted on edge E: portD_enable is high during the cycle after E.
- ALU result accepted on edge E into an empty FIFO with no load traffic: popped on E+1, so portD_enable is high during the cycle after E+1.
REQ-025 Push and pop on the same edge are allowed; fifo_count changes by +1, 0 or -1 accordingly.
REQ-026 FIFO pointers wrap modulo ALU_FIFO_DEPTH; entry order is strictly FIFO.
REQ-027 busy_mask bit k is 1 iff any valid FIFO entry has key k, or (portD_enable and portD_key == k); bit 0 is always 0.
REQ-028 fifo_count never exceeds ALU_FIFO_DEPTH; pops from an empty FIFO never occur.
REQ-029 Under continuous load traffic the FIFO is not drained (load priority is strict); the upstream stage is responsible for bubbles.

Reset
REQ-030 While reset_n is low, regardless of clk:
- portD_enable, portD_key, portD_value, busy_mask and fifo_count are 0.
- alu_ready and mem_ready are 0.
- The FIFO is empty.
REQ-031 Reset asserted mid-operation discards all buffered results; nothing from before reset is written after release.
REQ-032 After reset_n rises, the first edge operates normally and both ready outputs follow REQ-018 and REQ-020.

Verification
REQ-033 ALU-only path: alu_valid=1, key=5, value=0x11111111 for one cycle, no loads -> portD_enable=1, key=5, value=0x11111111 one cycle after the pop edge; busy_mask bit 5 high from the accept edge until portD_enable drops.
REQ-034 Simultaneous traffic: ALU key=3 value=0xA and load key=4 value=0xB on the same edge -> port D writes key 4 (0xB) first, then key 3 (0xA) on the next cycle.
REQ-035 Backpressure: DEPTH=2, mem_valid held high with keys 7,8,9, three ALU results offered -> alu_ready=0 after two pushes, fifo_count=2, no result lost; after mem_valid drops the ALU results drain in order.
REQ-036 Ordering hazard: FIFO holds key 6; load offered with key 6 -> mem_ready=0 until the key-6 entry is popped, then the load is accepted and written after it.
REQ-037 x0 writes: ALU and load with key 0 -> both handshakes complete, portD_enable stays 0, busy_mask=0, fifo_count unchanged.
REQ-038 Reset mid-stream: FIFO holding two entries, reset_n pulsed low between edges -> all outputs 0 immediately; after release no pre-reset write appears on port D.
